ahbl_rr_grant_sched: RTL and testbench

Round-robin grant scheduler for an N:1 AHB-Lite arbiter. It produces a one-hot address-phase grant from per-master requests and advances its priority pointer only when the downstream slave accepts an address phase. It holds the grant on the current owner during locked (hmastlock) sequences and tracks per-master starvation. It sits between master request decode and the arbiter's address-phase muxes, replacing fixed priority selection.

---
 rtl/ahbl_rr_grant_sched_if.sv | 23 ++
 rtl/ahbl_rr_grant_sched.sv | 130 +++++++++++++
 tb/tb_ahbl_rr_grant_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_rr_grant_sched_if.sv
// Request/grant bundle between the AHB-Lite master request decode and the
// round-robin grant scheduler.
interface ahbl_rr_grant_sched_if #(
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] lock;
  logic               accept;
  logic [N_PORTS-1:0] gnt;
  logic               lock_active;
  logic [N_PORTS-1:0] lock_owner;
  logic [N_PORTS-1:0] starve;

  modport master (
    output req, lock, accept,
    input  gnt, lock_active, lock_owner, starve
  );

  modport slave (
    input  req, lock, accept,
    output gnt, lock_active, lock_owner, starve
  );
endinterface

// File: rtl/ahbl_rr_grant_sched.sv
// Round-robin address-phase grant scheduler for an N:1 AHB-Lite arbiter with
// HMASTLOCK hold and starvation tracking. Define ARB_STARVE_BOOST_EN to let
// starved requesters pre-empt round-robin order.
module ahbl_rr_grant_sched #(
  parameter int N_PORTS      = 2,
  parameter int W_CNT        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ahbl_rr_grant_sched_if.slave       bus
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic               lock_active_q, lock_active_d;
  logic [N_PORTS-1:0] lock_owner_q, lock_owner_d;
  logic [W_CNT-1:0]   cnt_q [N_PORTS];
  logic [W_CNT-1:0]   cnt_d [N_PORTS];

  logic [N_PORTS-1:0] hi_mask;
  logic [N_PORTS-1:0] req_hi;
  logic [N_PORTS-1:0] gnt_rr;
  logic [N_PORTS-1:0] gnt;
  logic [N_PORTS-1:0] starve;
  logic [PW-1:0]      gnt_idx;
  logic               own_req;
  logic               own_lock;

  function automatic logic [N_PORTS-1:0] lowest1(input logic [N_PORTS-1:0] v);
    return v & (~v + N_PORTS'(1));
  endfunction

  // Round-robin: lowest request at or above ptr, otherwise wrap to lowest overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      hi_mask[i] = (PW'(i) >= ptr_q);
    end
    req_hi = bus.req & hi_mask;
    gnt_rr = (req_hi != '0) ? lowest1(req_hi) : lowest1(bus.req);
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      starve[i] = (cnt_q[i] >= W_CNT'(STARVE_LIMIT));
    end
  end

  always_comb begin
    if (lock_active_q) begin
      gnt = lock_owner_q & bus.req;
    end else begin
`ifdef ARB_STARVE_BOOST_EN
      gnt = ((starve & bus.req) != '0) ? lowest1(starve & bus.req) : gnt_rr;
`else
      gnt = gnt_rr;
`endif
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  assign own_req  = |(bus.req  & lock_owner_q);
  assign own_lock = |(bus.lock & lock_owner_q);

  always_comb begin
    ptr_d         = ptr_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    if (!lock_active_q) begin
      if (bus.accept && (gnt != '0)) begin
        ptr_d = (gnt_idx == PW'(N_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
        if ((gnt & bus.lock) != '0) begin
          lock_active_d = 1'b1;
          lock_owner_d  = gnt;
        end
      end
    end else if (!own_lock && ((bus.accept && own_req) || !own_req)) begin
      // Owner finished its locked sequence or went idle unlocked.
      lock_active_d = 1'b0;
      lock_owner_d  = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!bus.req[i]) begin
        cnt_d[i] = '0;
      end else if (bus.accept) begin
        if (gnt[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] < W_CNT'(STARVE_LIMIT)) begin
          cnt_d[i] = cnt_q[i] + W_CNT'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      for (int i = 0; i < N_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gnt         = gnt;
  assign bus.lock_active = lock_active_q;
  assign bus.lock_owner  = lock_owner_q;
  assign bus.starve      = starve;

endmodule

// File: tb/tb_ahbl_rr_grant_sched.sv
// Directed bench for ahbl_rr_grant_sched (3 ports, starvation limit 2) with a
// behavioural scheduler model compared every cycle plus literal expectations.
module tb_ahbl_rr_grant_sched;

  localparam int N   = 3;
  localparam int LIM = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ahbl_rr_grant_sched_if #(.N_PORTS(N)) bus ();

  ahbl_rr_grant_sched #(
    .N_PORTS(N), .W_CNT(4), .STARVE_LIMIT(LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pointer index, owner index (-1 = unlocked), wait counts.
  int m_ptr = 0;
  int m_own = -1;
  int m_cnt [N] = '{0, 0, 0};

  function automatic logic [N-1:0] oh(input int i);
    return 3'b001 << i;
  endfunction

  function automatic bit has(input logic [N-1:0] v, input int i);
    return (v & oh(i)) != '0;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (has(v, i)) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] mdl_gnt(input logic [N-1:0] r);
    if (m_own >= 0) return has(r, m_own) ? oh(m_own) : '0;
`ifdef ARB_STARVE_BOOST_EN
    for (int i = 0; i < N; i++) if (m_cnt[i] >= LIM && has(r, i)) return oh(i);
`endif
    for (int k = 0; k < N; k++) if (has(r, (m_ptr + k) % N)) return oh((m_ptr + k) % N);
    return '0;
  endfunction

  function automatic int nxt_ptr(input logic [N-1:0] r, input logic a);
    logic [N-1:0] g;
    g = mdl_gnt(r);
    if (m_own < 0 && a && g != '0) return (idx_of(g) + 1) % N;
    return m_ptr;
  endfunction

  function automatic int nxt_own(input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
    logic [N-1:0] g;
    g = mdl_gnt(r);
    if (m_own < 0) return (a && g != '0 && (l & g) != '0) ? idx_of(g) : -1;
    if (!has(l, m_own) && ((a && g == oh(m_own)) || !has(r, m_own))) return -1;
    return m_own;
  endfunction

  function automatic int nxt_cnt(input int i, input logic [N-1:0] r, input logic a);
    logic [N-1:0] g;
    g = mdl_gnt(r);
    if (!has(r, i)) return 0;
    if (!a) return m_cnt[i];
    if (has(g, i)) return 0;
    return (m_cnt[i] + 1 > LIM) ? LIM : m_cnt[i] + 1;
  endfunction

  function automatic logic [N-1:0] mdl_starve();
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) if (m_cnt[i] >= LIM) s |= oh(i);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0;
      m_own <= -1;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      m_ptr <= nxt_ptr(bus.req, bus.accept);
      m_own <= nxt_own(bus.req, bus.lock, bus.accept);
      for (int i = 0; i < N; i++) m_cnt[i] <= nxt_cnt(i, bus.req, bus.accept);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mdl_gnt", bus.gnt, mdl_gnt(bus.req));
    chk("mdl_lock_active", {2'b00, bus.lock_active}, {2'b00, m_own >= 0});
    chk("mdl_lock_owner", bus.lock_owner, (m_own >= 0) ? oh(m_own) : '0);
    chk("mdl_starve", bus.starve, mdl_starve());
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
    @(posedge clk);
    #2;
    bus.req    = r;
    bus.lock   = l;
    bus.accept = a;
    #2;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.lock   = '0;
    bus.accept = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_gnt", bus.gnt, 3'b000);
    chk("rst_lock_active", {2'b00, bus.lock_active}, 3'b000);
    chk("rst_starve", bus.starve, 3'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full request, accept every cycle: pointer walks and wraps.
    cyc(3'b111, 3'b000, 1'b1); chk("rr_0", bus.gnt, 3'b001);
    cyc(3'b111, 3'b000, 1'b1); chk("rr_1", bus.gnt, 3'b010);
    cyc(3'b111, 3'b000, 1'b1); chk("rr_2", bus.gnt, 3'b100);
    cyc(3'b111, 3'b000, 1'b1); chk("rr_wrap", bus.gnt, 3'b001);
    cyc(3'b000, 3'b000, 1'b0); chk("idle_gnt", bus.gnt, 3'b000);

    // ptr=1, no accepts: grant holds on port2.
    for (int i = 0; i < 5; i++) begin
      cyc(3'b101, 3'b000, 1'b0); chk("hold_noacc", bus.gnt, 3'b100);
    end
    cyc(3'b101, 3'b000, 1'b1); chk("hold_acc", bus.gnt, 3'b100);
    cyc(3'b101, 3'b000, 1'b0); chk("after_acc", bus.gnt, 3'b001);
    cyc(3'b000, 3'b000, 1'b0);

    // Port1 locked sequence.
    cyc(3'b010, 3'b010, 1'b1); chk("lk_entry", bus.gnt, 3'b010);
    for (int i = 0; i < 4; i++) begin
      cyc(3'b111, 3'b010, 1'b1);
      chk("lk_gnt", bus.gnt, 3'b010);
      chk("lk_active", {2'b00, bus.lock_active}, 3'b001);
      chk("lk_owner", bus.lock_owner, 3'b010);
    end
    cyc(3'b111, 3'b000, 1'b1);
    chk("lk_exit_gnt", bus.gnt, 3'b010);
    chk("lk_exit_starve", bus.starve, 3'b101);
    cyc(3'b111, 3'b000, 1'b0);
    chk("lk_after_active", {2'b00, bus.lock_active}, 3'b000);
`ifdef ARB_STARVE_BOOST_EN
    chk("lk_after_gnt", bus.gnt, 3'b001);
`else
    chk("lk_after_gnt", bus.gnt, 3'b100);
`endif
    cyc(3'b000, 3'b000, 1'b0);

    // Locked owner port0 goes idle unlocked while port2 requests.
    cyc(3'b001, 3'b001, 1'b1); chk("idle_entry", bus.gnt, 3'b001);
    cyc(3'b100, 3'b000, 1'b1);
    chk("idle_gnt_zero", bus.gnt, 3'b000);
    chk("idle_still_lk", {2'b00, bus.lock_active}, 3'b001);
    cyc(3'b100, 3'b000, 1'b0);
    chk("idle_unlocked", {2'b00, bus.lock_active}, 3'b000);
    chk("idle_next_gnt", bus.gnt, 3'b100);
    cyc(3'b000, 3'b000, 1'b0);

    // Port2 starves behind a port0 lock.
    cyc(3'b001, 3'b001, 1'b1); chk("st_entry", bus.gnt, 3'b001);
    cyc(3'b101, 3'b001, 1'b1); chk("st_lk1", bus.gnt, 3'b001);
    cyc(3'b101, 3'b001, 1'b1); chk("st_lk2", bus.gnt, 3'b001);
    cyc(3'b101, 3'b000, 1'b1);
    chk("st_flag", bus.starve, 3'b100);
    chk("st_exit_gnt", bus.gnt, 3'b001);
    cyc(3'b111, 3'b000, 1'b0);
`ifdef ARB_STARVE_BOOST_EN
    chk("st_boost_gnt", bus.gnt, 3'b100);
`else
    chk("st_rr_gnt", bus.gnt, 3'b010);
`endif
    cyc(3'b000, 3'b000, 1'b0);

    // Asynchronous reset in the middle of a port1 lock with ptr=2.
    cyc(3'b010, 3'b010, 1'b1); chk("rs_entry", bus.gnt, 3'b010);
    cyc(3'b011, 3'b010, 1'b1); chk("rs_locked", bus.gnt, 3'b010);
    @(posedge clk);
    #2;
    bus.req    = 3'b101;
    bus.lock   = 3'b000;
    bus.accept = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rs_gnt", bus.gnt, 3'b001);
    chk("rs_lock_active", {2'b00, bus.lock_active}, 3'b000);
    chk("rs_lock_owner", bus.lock_owner, 3'b000);
    chk("rs_starve", bus.starve, 3'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(3'b101, 3'b000, 1'b1); chk("post_rs_acc", bus.gnt, 3'b001);
    cyc(3'b101, 3'b000, 1'b0); chk("post_rs_next", bus.gnt, 3'b100);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
